// File: rtl/scb_pkg.sv
// Shared sizing for the register scoreboard.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package scb_pkg;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 2;

    typedef logic [IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/scb_entry.sv
// One register's pending-write / pending-load counter pair with saturation checks.
// Latency: counters update on the next edge; busy flags and err are combinational from state and events.
// Backpressure: none; every event is consumed, and illegal ones raise err.
module scb_entry
    import scb_pkg::*;
#(
    parameter int CNT_W = scb_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    input  logic ld_inc,
    input  logic dec,
    input  logic ld_dec,
    output logic busy,
    output logic load_busy,
    output logic err
`ifdef SCB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] pend_nxt;
    logic [CNT_W-1:0] load_nxt;

    always_comb begin
        pend_nxt = pend_cnt;
        load_nxt = load_cnt;
        err      = 1'b0;

        // Matching +1/-1 in the same cycle cancel out and are always legal.
        if (inc && !dec) begin
            if (pend_cnt == CNT_MAX) err = 1'b1;
            else                     pend_nxt = pend_cnt + 1'b1;
        end else if (dec && !inc) begin
            if (pend_cnt == '0) err = 1'b1;
            else                pend_nxt = pend_cnt - 1'b1;
        end

        if (ld_inc && !ld_dec) begin
            if (load_cnt == CNT_MAX) err = 1'b1;
            else                     load_nxt = load_cnt + 1'b1;
        end else if (ld_dec && !ld_inc) begin
            if (load_cnt == '0) err = 1'b1;
            else                load_nxt = load_cnt - 1'b1;
        end

        // A load can never outlive its own pending write.
        if (load_nxt > pend_nxt) begin
            err      = 1'b1;
            load_nxt = pend_nxt;
        end

        if (clear) begin
            pend_nxt = '0;
            load_nxt = '0;
            err      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= '0;
            load_cnt <= '0;
        end else begin
            pend_cnt <= pend_nxt;
            load_cnt <= load_nxt;
        end
    end

    assign busy      = (pend_cnt != '0);
    assign load_busy = (load_cnt != '0);
`ifdef SCB_STATS_EN
    assign cnt       = pend_cnt;
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write tracker producing the ID-stage stall; SCB_STATS_EN adds stall/in-flight stats.
// Latency: stall is combinational from state and sources; state and sticky err update on the next edge.
// Backpressure: stall holds ID; issues seen while stalled are dropped as bubbles.
module reg_scoreboard
    import scb_pkg::*;
#(
    parameter int NUM_REGS = scb_pkg::NUM_REGS,
    parameter int IDX_W    = scb_pkg::IDX_W,
    parameter int CNT_W    = scb_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             issue_valid,
    input  logic             issue_wb_en,
    input  logic             issue_is_load,
    input  logic [IDX_W-1:0] issue_dest,
    input  logic             ld_done_valid,
    input  logic [IDX_W-1:0] ld_done_dest,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_dest,
    input  logic [IDX_W-1:0] src1,
    input  logic [IDX_W-1:0] src2,
    input  logic             two_src,
    input  logic             fwd_en,
    output logic             stall,
    output logic             err
`ifdef SCB_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [IDX_W+CNT_W-1:0] max_inflight
`endif
);

    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] load_vec;
    logic [NUM_REGS-1:0] err_vec;
    logic [NUM_REGS-1:0] hazard_vec;
    logic                issue_acc;

`ifdef SCB_STATS_EN
    localparam int SUM_W = IDX_W + CNT_W;
    logic [CNT_W-1:0] cnt_vec [NUM_REGS];
    logic [SUM_W-1:0] inflight_sum;
`endif

    // With forwarding only loads still waiting on memory are hazards.
    assign hazard_vec = fwd_en ? load_vec : busy_vec;
    assign stall      = hazard_vec[src1] | (two_src & hazard_vec[src2]);
    assign issue_acc  = issue_valid & issue_wb_en & ~stall;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        logic inc;
        logic dec;
        logic ld_dec;

        assign inc    = issue_acc & (issue_dest == IDX_W'(g));
        assign dec    = wb_valid & (wb_dest == IDX_W'(g));
        assign ld_dec = ld_done_valid & (ld_done_dest == IDX_W'(g));

        scb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .inc       (inc),
            .ld_inc    (inc & issue_is_load),
            .dec       (dec),
            .ld_dec    (ld_dec),
            .busy      (busy_vec[g]),
            .load_busy (load_vec[g]),
            .err       (err_vec[g])
`ifdef SCB_STATS_EN
            ,
            .cnt       (cnt_vec[g])
`endif
        );
    end

    // Only reset clears err; a flush leaves the evidence in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err | (|err_vec);
    end

`ifdef SCB_STATS_EN
    always_comb begin
        inflight_sum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inflight_sum = inflight_sum + SUM_W'(cnt_vec[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            max_inflight <= '0;
        end else if (clear) begin
            stall_cycles <= '0;
            max_inflight <= '0;
        end else begin
            if (stall && issue_valid) stall_cycles <= stall_cycles + 32'd1;
            if (inflight_sum > max_inflight) max_inflight <= inflight_sum;
        end
    end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scenario bench for reg_scoreboard: expectations queued at stimulus time, popped at sampling time.
`timescale 1ns/100ps
module tb_reg_scoreboard;
    import scb_pkg::*;

    logic     clk;
    logic     rst_n;
    logic     clear;
    logic     issue_valid;
    logic     issue_wb_en;
    logic     issue_is_load;
    reg_idx_t issue_dest;
    logic     ld_done_valid;
    reg_idx_t ld_done_dest;
    logic     wb_valid;
    reg_idx_t wb_dest;
    reg_idx_t src1;
    reg_idx_t src2;
    logic     two_src;
    logic     fwd_en;
    logic     stall;
    logic     err;
`ifdef SCB_STATS_EN
    logic [31:0]            stall_cycles;
    logic [IDX_W+CNT_W-1:0] max_inflight;
`endif

    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    logic [31:0] e;

    reg_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .issue_valid   (issue_valid),
        .issue_wb_en   (issue_wb_en),
        .issue_is_load (issue_is_load),
        .issue_dest    (issue_dest),
        .ld_done_valid (ld_done_valid),
        .ld_done_dest  (ld_done_dest),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .src1          (src1),
        .src2          (src2),
        .two_src       (two_src),
        .fwd_en        (fwd_en),
        .stall         (stall),
        .err           (err)
`ifdef SCB_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .max_inflight  (max_inflight)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        clear = 0; issue_valid = 0; issue_wb_en = 0; issue_is_load = 0; issue_dest = '0;
        ld_done_valid = 0; ld_done_dest = '0; wb_valid = 0; wb_dest = '0;
        src1 = '0; src2 = '0; two_src = 0; fwd_en = 0;
    endtask

    task automatic issue(input reg_idx_t d, input logic ld);
        issue_valid = 1; issue_wb_en = 1; issue_is_load = ld; issue_dest = d;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0;
        src1 = 4'd3; src2 = 4'd15; two_src = 1;
        q.push_back(32'd0); q.push_back(32'd0);
        @(posedge clk); @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL reset_stall: stall=%b expected %b", stall, e[0]); end
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL reset_err: err=%b expected %b", err, e[0]); end
`ifdef SCB_STATS_EN
        q.push_back(32'd0); q.push_back(32'd0);
        e = q.pop_front(); n_run++;
        if (stall_cycles !== e) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d expected %0d", stall_cycles, e); end
        e = q.pop_front(); n_run++;
        if (max_inflight !== e[IDX_W+CNT_W-1:0]) begin n_fail++; $display("FAIL reset_max_inflight: got %0d expected %0d", max_inflight, e); end
`endif
        @(posedge clk); #1 rst_n = 1;
        idle(); fwd_en = 1; src1 = 4'd15; q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL reset_release_stall: stall=%b expected %b", stall, e[0]); end
        next_cycle();
    endtask

    task automatic test_basic();
        idle(); issue(4'd3, 0);
        next_cycle();
        idle(); src1 = 4'd3; wb_valid = 1; wb_dest = 4'd3; q.push_back(32'd1);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL r3_busy_nofwd: stall=%b expected %b", stall, e[0]); end
        fwd_en = 1; q.push_back(32'd0); #1;
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL r3_fwd: stall=%b expected %b", stall, e[0]); end
        next_cycle();
        idle(); src1 = 4'd3; q.push_back(32'd0); q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL r3_after_wb: stall=%b expected %b", stall, e[0]); end
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL r3_err: err=%b expected %b", err, e[0]); end
        next_cycle();
    endtask

    task automatic test_fwd_load();
        idle(); issue(4'd5, 1);
        next_cycle();
        idle(); fwd_en = 1; src2 = 4'd5; two_src = 1; q.push_back(32'd1);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL ld_r5_stall: stall=%b expected %b", stall, e[0]); end
        two_src = 0; q.push_back(32'd0); #1;
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL ld_r5_one_src: stall=%b expected %b", stall, e[0]); end
        next_cycle();
        idle(); fwd_en = 1; src2 = 4'd5; two_src = 1; ld_done_valid = 1; ld_done_dest = 4'd5;
        q.push_back(32'd1);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL ld_r5_done_cycle: stall=%b expected %b", stall, e[0]); end
        next_cycle();
        idle(); fwd_en = 1; src2 = 4'd5; two_src = 1; wb_valid = 1; wb_dest = 4'd5;
        q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL ld_r5_after_done: stall=%b expected %b", stall, e[0]); end
        next_cycle();
        idle(); src2 = 4'd5; two_src = 1; q.push_back(32'd0); q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL ld_r5_retired: stall=%b expected %b", stall, e[0]); end
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL ld_r5_err: err=%b expected %b", err, e[0]); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        idle(); issue(4'd7, 0);
        next_cycle();
        idle(); issue(4'd7, 0);
        next_cycle();
        // Expected stall for the three wb cycles: 2 pending, 1 pending, drained.
        for (int i = 0; i < 3; i++) begin
            idle(); src1 = 4'd7; wb_valid = 1; wb_dest = 4'd7;
            q.push_back((i < 2) ? 32'd1 : 32'd0);
            @(negedge clk);
            e = q.pop_front(); n_run++;
            if (stall !== e[0]) begin n_fail++; $display("FAIL r7_wb%0d_stall: stall=%b expected %b", i, stall, e[0]); end
            if (i == 2) begin
                q.push_back(32'd0);
                e = q.pop_front(); n_run++;
                if (err !== e[0]) begin n_fail++; $display("FAIL r7_err_before: err=%b expected %b", err, e[0]); end
            end
            next_cycle();
        end
        idle(); q.push_back(32'd1);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL r7_underflow_err: err=%b expected %b", err, e[0]); end
        do_reset();
    endtask

    task automatic test_same_cycle();
        idle(); issue(4'd2, 0);
        next_cycle();
        idle(); issue(4'd2, 0); wb_valid = 1; wb_dest = 4'd2;
        next_cycle();
        idle(); issue(4'd2, 0); src1 = 4'd2; q.push_back(32'd1); q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL r2_net_zero: stall=%b expected %b", stall, e[0]); end
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL r2_net_zero_err: err=%b expected %b", err, e[0]); end
        next_cycle();
        idle(); src1 = 4'd2; wb_valid = 1; wb_dest = 4'd2; q.push_back(32'd1);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL r2_count_one: stall=%b expected %b", stall, e[0]); end
        next_cycle();
        idle(); src1 = 4'd2; q.push_back(32'd0); q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL r2_stalled_issue_dropped: stall=%b expected %b", stall, e[0]); end
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL r2_err: err=%b expected %b", err, e[0]); end
        next_cycle();
    endtask

    task automatic test_saturate_clear();
        logic any_stall;
        for (int i = 0; i < 4; i++) begin
            idle(); issue(4'd4, 0);
            if (i == 3) begin
                q.push_back(32'd0);
                @(negedge clk);
                e = q.pop_front(); n_run++;
                if (err !== e[0]) begin n_fail++; $display("FAIL r4_no_err_at_max: err=%b expected %b", err, e[0]); end
            end
            next_cycle();
        end
        // Held at 3: two retirements still leave the register busy.
        for (int i = 0; i < 3; i++) begin
            idle(); src1 = 4'd4;
            if (i < 2) begin wb_valid = 1; wb_dest = 4'd4; end
            q.push_back(32'd1); q.push_back(32'd1);
            @(negedge clk);
            e = q.pop_front(); n_run++;
            if (stall !== e[0]) begin n_fail++; $display("FAIL r4_held%0d_stall: stall=%b expected %b", i, stall, e[0]); end
            e = q.pop_front(); n_run++;
            if (err !== e[0]) begin n_fail++; $display("FAIL r4_held%0d_err: err=%b expected %b", i, err, e[0]); end
            next_cycle();
        end
        idle(); clear = 1; issue(4'd9, 0); wb_valid = 1; wb_dest = 4'd4;
        next_cycle();
        idle(); any_stall = 0;
        for (int i = 0; i < 16; i++) begin
            src1 = reg_idx_t'(i); #0.2;
            any_stall = any_stall | stall;
        end
        q.push_back(32'd0); q.push_back(32'd1);
        e = q.pop_front(); n_run++;
        if (any_stall !== e[0]) begin n_fail++; $display("FAIL clear_all_idle: any_stall=%b expected %b", any_stall, e[0]); end
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL clear_keeps_err: err=%b expected %b", err, e[0]); end
        rst_n = 0; q.push_back(32'd0); #1;
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL async_reset_err: err=%b expected %b", err, e[0]); end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_load_clamp();
        idle(); issue(4'd6, 1);
        next_cycle();
        idle(); wb_valid = 1; wb_dest = 4'd6; q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL clamp_err_before: err=%b expected %b", err, e[0]); end
        next_cycle();
        idle(); fwd_en = 1; src1 = 4'd6; q.push_back(32'd0); q.push_back(32'd1);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall !== e[0]) begin n_fail++; $display("FAIL clamp_load_forced: stall=%b expected %b", stall, e[0]); end
        e = q.pop_front(); n_run++;
        if (err !== e[0]) begin n_fail++; $display("FAIL clamp_err: err=%b expected %b", err, e[0]); end
        do_reset();
    endtask

`ifdef SCB_STATS_EN
    task automatic test_stats();
        idle(); issue(4'd1, 0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            idle(); issue(4'd8, 0); src1 = 4'd1;
            next_cycle();
        end
        idle(); clear = 1; q.push_back(32'd5); q.push_back(32'd1);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall_cycles !== e) begin n_fail++; $display("FAIL stats_stall_cycles: got %0d expected %0d", stall_cycles, e); end
        e = q.pop_front(); n_run++;
        if (max_inflight !== e[IDX_W+CNT_W-1:0]) begin n_fail++; $display("FAIL stats_max_one: got %0d expected %0d", max_inflight, e); end
        next_cycle();
        idle(); issue(4'd9, 0); q.push_back(32'd0);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (stall_cycles !== e) begin n_fail++; $display("FAIL stats_clear: got %0d expected %0d", stall_cycles, e); end
        next_cycle();
        idle(); issue(4'd10, 0);
        next_cycle();
        idle(); issue(4'd11, 0);
        next_cycle();
        idle();
        next_cycle();
        idle(); wb_valid = 1; wb_dest = 4'd9; q.push_back(32'd3);
        @(negedge clk);
        e = q.pop_front(); n_run++;
        if (max_inflight !== e[IDX_W+CNT_W-1:0]) begin n_fail++; $display("FAIL stats_max_three: got %0d expected %0d", max_inflight, e); end
        next_cycle();
        idle(); q.push_back(32'd3);
        next_cycle();
        e = q.pop_front(); n_run++;
        if (max_inflight !== e[IDX_W+CNT_W-1:0]) begin n_fail++; $display("FAIL stats_max_holds: got %0d expected %0d", max_inflight, e); end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fwd_load();
        test_back_to_back();
        test_same_cycle();
        test_saturate_clear();
        test_load_clamp();
`ifdef SCB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight register writes between issue (ID->EXE) and writeback, replacing the pure pipeline-snoop dependency check with explicit per-register pending state.
- Writer side: issue and retire events set and clear pending counts. Reader side: ID-stage source queries produce a stall.
- Supports multi-cycle memory: loads stay "unforwardable" until the memory stage signals data return.
- Sits beside the ID stage. Its stall output feeds the PC/IF-ID freeze logic.

Parameters:
- NUM_REGS, 16, number of architectural registers.
- IDX_W, 4, register index width (log2 NUM_REGS).
- CNT_W, 2, per-register pending counter width; at most 2^CNT_W-1 writes in flight per register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all counters (pipeline flush-all).
- issue_valid  in  1  instruction leaving ID this cycle.
- issue_wb_en  in  1  issued instruction writes a register.
- issue_is_load  in  1  issued instruction is a memory read.
- issue_dest  in  IDX_W  destination register of the issued instruction.
- ld_done_valid  in  1  load data available in MEM (forwardable from next cycle).
- ld_done_dest  in  IDX_W  destination of the completed load.
- wb_valid  in  1  register-file write this cycle.
- wb_dest  in  IDX_W  destination written.
- src1  in  IDX_W  ID source Rn.
- src2  in  IDX_W  ID source Rm/Rd.
- two_src  in  1  src2 is meaningful.
- fwd_en  in  1  forwarding enabled.
- stall  out  1  ID must hold.
- err  out  1  sticky protocol-error flag.

Behaviour:
- State: per register, pend_cnt[r] (CNT_W) and load_cnt[r] (CNT_W).
- Reset (rst_n=0, asynchronous): all counters 0, err=0. stall then follows the combinational rule below and is 0 with cleared state.
- stall is combinational from current state and src inputs, with no added latency:
  - fwd_en=0: stall = busy(src1) | (two_src & busy(src2)), where busy = pend_cnt!=0.
  - fwd_en=1: stall = same expression with busy = load_cnt!=0.
- An issue is accepted only when issue_valid & issue_wb_en & !stall. Otherwise it is a bubble with no state change.
- Accepted issue: pend_cnt[issue_dest]+1. If issue_is_load, also load_cnt[issue_dest]+1.
- ld_done_valid: load_cnt[ld_done_dest]-1.
- wb_valid: pend_cnt[wb_dest]-1.
- Simultaneous events on the same register in one cycle combine as a net delta: +1 and -1 give no change. The lower counter sees the same rule.
- Saturation:
  - An increment at max holds max and sets err.
  - A decrement at 0 holds 0 and sets err.
  - If a decrement and an increment combine to net 0, no error is raised.
- load_cnt must never exceed pend_cnt. A wb_valid that would leave pend_cnt < load_cnt sets err, and load_cnt is forced down to the new pend_cnt.
- clear=1: all counters go to 0 next edge. Same-cycle issue, ld_done and wb events are ignored. err is not cleared; only reset clears err.
- Reset asserted mid-operation discards all in-flight tracking immediately. Upstream must not retire pre-reset instructions after reset is released.
- Register index 15 (PC) is tracked like any other; no special case.

Optional Feature:
- Macro: SCB_STATS_EN.
- When defined, adds outputs stall_cycles (32 bit) and max_inflight (IDX_W+CNT_W bit).
  - stall_cycles: counts cycles with stall=1 and issue_valid=1; wraps at 2^32.
  - max_inflight: high-water mark of the sum of all pend_cnt.
  - Both reset to 0 on rst_n and on clear.
- When undefined, these ports and their logic do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package scb_pkg holds: NUM_REGS, IDX_W and CNT_W defaults, and a reg_idx_t typedef.
- Natural sub-module scb_entry: one register's pend/load counter pair, with inc/dec/ld_dec/clear inputs, busy/load_busy outputs and an overflow/underflow error output.
- The top instantiates NUM_REGS entries via generate, plus the stall mux and err OR-reduction.

Test Plan:
- Reset then issue r3 (wb_en, no load) -> next cycle, src1=3 with fwd_en=0 gives stall=1 and with fwd_en=1 gives stall=0. After wb_valid wb_dest=3, stall=0.
- Issue load r5, fwd_en=1, src2=5, two_src=1 -> stall=1 until the cycle after ld_done_valid dest=5. With two_src=0 -> stall=0 throughout.
- Issue r7 twice back-to-back, then one wb r7 -> pend_cnt=1, so stall still 1 for fwd_en=0. The second wb clears it; a third wb raises err=1.
- Same cycle: issue r2 plus wb r2 with pend_cnt[2]=1 -> count stays 1, err=0. Issue attempted while stall=1 -> no count change.
- Four consecutive accepted issues to r4 with CNT_W=2 -> count holds 3, err=1. Then clear -> all stall=0 next cycle and err stays 1. Then rst_n pulse low mid-cycle -> err=0 immediately.
- SCB_STATS_EN defined: five stalled issue cycles -> stall_cycles=5. Three distinct regs in flight -> max_inflight=3.
